hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and control unit for the 5-stage pipeline: EX forwarding selects,
// load-use stalls, redirect flushes, data-memory wait freezes and a stall counter.
module hazard_ctrl #(
   parameter int REG_AW  = 5,
   parameter int MEM_LAT = 1,
   parameter int CNT_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] ID_rs1_i,
   input  logic [REG_AW-1:0] ID_rs2_i,
   input  logic              ID_rs1_used_i,
   input  logic              ID_rs2_used_i,
   input  logic [REG_AW-1:0] EX_rs1_i,
   input  logic [REG_AW-1:0] EX_rs2_i,
   input  logic [REG_AW-1:0] EX_rd_i,
   input  logic              EX_RegWrite_i,
   input  logic              EX_MemRead_i,
   input  logic [REG_AW-1:0] MEM_rd_i,
   input  logic              MEM_RegWrite_i,
   input  logic              MEM_MemRead_i,
   input  logic [REG_AW-1:0] WB_rd_i,
   input  logic              WB_RegWrite_i,
   input  logic              EX_redirect_i,
   output logic              pc_en_o,
   output logic              IF_ID_en_o,
   output logic              ID_EX_en_o,
   output logic              EX_MEM_en_o,
   output logic              MEM_WB_en_o,
   output logic              IF_ID_flush_o,
   output logic              ID_EX_flush_o,
   output logic              MEM_WB_flush_o,
   output logic [1:0]        EX_forwardA_o,
   output logic [1:0]        EX_forwardB_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   localparam logic [1:0] FW_NONE = 2'b00;
   localparam logic [1:0] FW_MEM  = 2'b01;
   localparam logic [1:0] FW_WB   = 2'b10;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   localparam int             WCW       = $clog2(MEM_LAT + 1);
   localparam logic [WCW-1:0] WAIT_INIT = WCW'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);
   localparam logic [WCW-1:0] WAIT_ONE  = WCW'(1);

   logic [0:0]       r_state;
   logic [WCW-1:0]   r_wait_cnt;
   logic             r_served;
   logic [CNT_W-1:0] r_stall_cnt;

   logic w_start;
   logic w_freeze;
   logic w_load_use;

   function automatic logic [1:0] fwd_sel(
      input logic [REG_AW-1:0] rs,
      input logic [REG_AW-1:0] mem_rd,
      input logic              mem_wr,
      input logic              mem_rd_op,
      input logic [REG_AW-1:0] wb_rd,
      input logic              wb_wr
   );
      // A load in MEM has no data yet, so it is never a forwarding source.
      if (mem_wr && !mem_rd_op && (mem_rd != '0) && (mem_rd == rs))
         return FW_MEM;
      else if (wb_wr && (wb_rd != '0) && (wb_rd == rs))
         return FW_WB;
      else
         return FW_NONE;
   endfunction

   assign EX_forwardA_o = fwd_sel(EX_rs1_i, MEM_rd_i, MEM_RegWrite_i, MEM_MemRead_i,
                                  WB_rd_i, WB_RegWrite_i);
   assign EX_forwardB_o = fwd_sel(EX_rs2_i, MEM_rd_i, MEM_RegWrite_i, MEM_MemRead_i,
                                  WB_rd_i, WB_RegWrite_i);

   assign w_load_use = EX_MemRead_i && (EX_rd_i != '0) &&
                       ((ID_rs1_used_i && (EX_rd_i == ID_rs1_i)) ||
                        (ID_rs2_used_i && (EX_rd_i == ID_rs2_i)));

   assign w_start  = (r_state == S_IDLE) && MEM_MemRead_i && (MEM_LAT > 1) && !r_served;
   assign w_freeze = w_start || (r_state == S_WAIT);

   // r_wait_cnt holds the WAIT cycles still to come, so the whole freeze spans
   // MEM_LAT-1 cycles; a single-cycle freeze never needs the WAIT state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_wait_cnt <= '0;
         r_served   <= 1'b0;
      end else begin
         r_served <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  if (WAIT_INIT == '0) begin
                     r_served <= 1'b1;
                  end else begin
                     r_state    <= S_WAIT;
                     r_wait_cnt <= WAIT_INIT;
                  end
               end
            end
            S_WAIT: begin
               if (r_wait_cnt <= WAIT_ONE) begin
                  r_state    <= S_IDLE;
                  r_wait_cnt <= '0;
                  r_served   <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt - WAIT_ONE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // NOTE: every output gets a default first so no branch can infer a latch.
   always_comb begin
      pc_en_o        = 1'b1;
      IF_ID_en_o     = 1'b1;
      ID_EX_en_o     = 1'b1;
      EX_MEM_en_o    = 1'b1;
      MEM_WB_en_o    = 1'b1;
      IF_ID_flush_o  = 1'b0;
      ID_EX_flush_o  = 1'b0;
      MEM_WB_flush_o = 1'b0;
      if (w_freeze) begin
         pc_en_o        = 1'b0;
         IF_ID_en_o     = 1'b0;
         ID_EX_en_o     = 1'b0;
         EX_MEM_en_o    = 1'b0;
         MEM_WB_flush_o = 1'b1;
      end else if (EX_redirect_i) begin
         IF_ID_flush_o = 1'b1;
         ID_EX_flush_o = 1'b1;
      end else if (w_load_use) begin
         pc_en_o       = 1'b0;
         IF_ID_en_o    = 1'b0;
         ID_EX_flush_o = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_stall_cnt <= '0;
      else if (!pc_en_o && (r_stall_cnt != '1))
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
   end

   assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (MEM_LAT 1/3/4) share one
// input set; expected values are hand-computed constants.
module tb_hazard_ctrl;

   logic       clk;
   logic       rst;
   logic [4:0] ID_rs1, ID_rs2, EX_rs1, EX_rs2, EX_rd, MEM_rd, WB_rd;
   logic       ID_rs1_used, ID_rs2_used, EX_RegWrite, EX_MemRead;
   logic       MEM_RegWrite, MEM_MemRead, WB_RegWrite, EX_redirect;

   // en = {pc, IF_ID, ID_EX, EX_MEM, MEM_WB}, fl = {IF_ID, ID_EX, MEM_WB}
   logic [4:0]  d1_en, d3_en, d4_en;
   logic [2:0]  d1_fl, d3_fl, d4_fl;
   logic [1:0]  d1_fa, d1_fb, d3_fa, d3_fb, d4_fa, d4_fb;
   logic [31:0] d1_cnt, d4_cnt;
   logic [3:0]  d3_cnt;

   int checks   = 0;
   int failures = 0;

   hazard_ctrl #(.REG_AW(5), .MEM_LAT(1), .CNT_W(32)) u_d1 (
      .clk(clk), .rst(rst),
      .ID_rs1_i(ID_rs1), .ID_rs2_i(ID_rs2), .ID_rs1_used_i(ID_rs1_used), .ID_rs2_used_i(ID_rs2_used),
      .EX_rs1_i(EX_rs1), .EX_rs2_i(EX_rs2), .EX_rd_i(EX_rd), .EX_RegWrite_i(EX_RegWrite),
      .EX_MemRead_i(EX_MemRead), .MEM_rd_i(MEM_rd), .MEM_RegWrite_i(MEM_RegWrite),
      .MEM_MemRead_i(MEM_MemRead), .WB_rd_i(WB_rd), .WB_RegWrite_i(WB_RegWrite),
      .EX_redirect_i(EX_redirect),
      .pc_en_o(d1_en[4]), .IF_ID_en_o(d1_en[3]), .ID_EX_en_o(d1_en[2]), .EX_MEM_en_o(d1_en[1]),
      .MEM_WB_en_o(d1_en[0]), .IF_ID_flush_o(d1_fl[2]), .ID_EX_flush_o(d1_fl[1]),
      .MEM_WB_flush_o(d1_fl[0]), .EX_forwardA_o(d1_fa), .EX_forwardB_o(d1_fb), .stall_cnt_o(d1_cnt)
   );

   hazard_ctrl #(.REG_AW(5), .MEM_LAT(3), .CNT_W(4)) u_d3 (
      .clk(clk), .rst(rst),
      .ID_rs1_i(ID_rs1), .ID_rs2_i(ID_rs2), .ID_rs1_used_i(ID_rs1_used), .ID_rs2_used_i(ID_rs2_used),
      .EX_rs1_i(EX_rs1), .EX_rs2_i(EX_rs2), .EX_rd_i(EX_rd), .EX_RegWrite_i(EX_RegWrite),
      .EX_MemRead_i(EX_MemRead), .MEM_rd_i(MEM_rd), .MEM_RegWrite_i(MEM_RegWrite),
      .MEM_MemRead_i(MEM_MemRead), .WB_rd_i(WB_rd), .WB_RegWrite_i(WB_RegWrite),
      .EX_redirect_i(EX_redirect),
      .pc_en_o(d3_en[4]), .IF_ID_en_o(d3_en[3]), .ID_EX_en_o(d3_en[2]), .EX_MEM_en_o(d3_en[1]),
      .MEM_WB_en_o(d3_en[0]), .IF_ID_flush_o(d3_fl[2]), .ID_EX_flush_o(d3_fl[1]),
      .MEM_WB_flush_o(d3_fl[0]), .EX_forwardA_o(d3_fa), .EX_forwardB_o(d3_fb), .stall_cnt_o(d3_cnt)
   );

   hazard_ctrl #(.REG_AW(5), .MEM_LAT(4), .CNT_W(32)) u_d4 (
      .clk(clk), .rst(rst),
      .ID_rs1_i(ID_rs1), .ID_rs2_i(ID_rs2), .ID_rs1_used_i(ID_rs1_used), .ID_rs2_used_i(ID_rs2_used),
      .EX_rs1_i(EX_rs1), .EX_rs2_i(EX_rs2), .EX_rd_i(EX_rd), .EX_RegWrite_i(EX_RegWrite),
      .EX_MemRead_i(EX_MemRead), .MEM_rd_i(MEM_rd), .MEM_RegWrite_i(MEM_RegWrite),
      .MEM_MemRead_i(MEM_MemRead), .WB_rd_i(WB_rd), .WB_RegWrite_i(WB_RegWrite),
      .EX_redirect_i(EX_redirect),
      .pc_en_o(d4_en[4]), .IF_ID_en_o(d4_en[3]), .ID_EX_en_o(d4_en[2]), .EX_MEM_en_o(d4_en[1]),
      .MEM_WB_en_o(d4_en[0]), .IF_ID_flush_o(d4_fl[2]), .ID_EX_flush_o(d4_fl[1]),
      .MEM_WB_flush_o(d4_fl[0]), .EX_forwardA_o(d4_fa), .EX_forwardB_o(d4_fb), .stall_cnt_o(d4_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      {ID_rs1, ID_rs2, EX_rs1, EX_rs2, EX_rd, MEM_rd, WB_rd} = '0;
      {ID_rs1_used, ID_rs2_used, EX_RegWrite, EX_MemRead} = '0;
      {MEM_RegWrite, MEM_MemRead, WB_RegWrite, EX_redirect} = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      #1;
      check("reset_en", d1_en, 5'b11111);
      check("reset_fl", d1_fl, 3'b000);
      check("reset_fa", d1_fa, 2'b00);
      check("reset_cnt", d1_cnt, 0);
      check("reset_en_lat3", d3_en, 5'b11111);

      // Forwarding
      MEM_rd = 5; MEM_RegWrite = 1; WB_rd = 5; WB_RegWrite = 1; EX_rs1 = 5; EX_rs2 = 9; #1;
      check("fwdA_mem_prio", d1_fa, 2'b01);
      check("fwdB_none", d1_fb, 2'b00);
      EX_rs2 = 5; #1;
      check("fwdB_mem", d1_fb, 2'b01);
      MEM_RegWrite = 0; #1;
      check("fwdA_wb", d1_fa, 2'b10);
      check("fwdB_wb", d1_fb, 2'b10);
      MEM_RegWrite = 1; MEM_MemRead = 1; #1;
      check("fwdA_load_in_mem", d1_fa, 2'b10);
      MEM_MemRead = 0; MEM_rd = 0; WB_rd = 0; EX_rs1 = 0; EX_rs2 = 0; #1;
      check("fwdA_x0", d1_fa, 2'b00);
      check("fwdB_x0", d1_fb, 2'b00);
      idle_inputs(); #1;

      // Load-use
      EX_MemRead = 1; EX_rd = 7; ID_rs2 = 7; ID_rs2_used = 1; #1;
      check("lu_en", d1_en, 5'b00111);
      check("lu_fl", d1_fl, 3'b010);
      check("lu_cnt_before", d1_cnt, 0);
      tick();
      EX_MemRead = 0; #1;
      check("lu_after_en", d1_en, 5'b11111);
      check("lu_cnt_after", d1_cnt, 1);
      EX_MemRead = 1; ID_rs2_used = 0; #1;
      check("lu_unused_rs2", d1_en, 5'b11111);
      ID_rs2_used = 1; EX_rd = 0; ID_rs2 = 0; #1;
      check("lu_rd_x0", d1_en, 5'b11111);
      EX_rd = 7; ID_rs1 = 7; ID_rs1_used = 1; ID_rs2_used = 0; #1;
      check("lu_rs1", d1_en, 5'b00111);

      // Redirect coinciding with load-use
      EX_redirect = 1; #1;
      check("redir_en", d1_en, 5'b11111);
      check("redir_fl", d1_fl, 3'b110);
      tick();
      check("redir_cnt", d1_cnt, 1);

      // Memory wait freeze, MEM_LAT=3 and 4
      do_reset();
      MEM_MemRead = 1; MEM_RegWrite = 1; MEM_rd = 4; #1;
      check("frz_A_en3", d3_en, 5'b00001);
      check("frz_A_fl3", d3_fl, 3'b001);
      check("frz_A_en4", d4_en, 5'b00001);
      check("frz_A_en1", d1_en, 5'b11111);
      tick();
      EX_redirect = 1; #1;
      check("frz_B_en3", d3_en, 5'b00001);
      check("frz_B_fl3_redir", d3_fl, 3'b001);
      check("frz_B_fl1_redir", d1_fl, 3'b110);
      EX_redirect = 0;
      tick();
      check("frz_C_en3", d3_en, 5'b11111);
      check("frz_C_fl3", d3_fl, 3'b000);
      check("frz_C_cnt3", d3_cnt, 2);
      check("frz_C_en4", d4_en, 5'b00001);
      tick();
      check("frz_D_en4", d4_en, 5'b11111);
      check("frz_D_cnt4", d4_cnt, 3);
      check("frz_D_en3_next_load", d3_en, 5'b00001);
      MEM_MemRead = 0; #1;
      check("frz_D_en3_idle", d3_en, 5'b11111);

      // Reset during the first WAIT cycle, MEM_LAT=4
      do_reset();
      MEM_MemRead = 1; #1;
      check("rstw_A_en4", d4_en, 5'b00001);
      tick();
      check("rstw_B_en4", d4_en, 5'b00001);
      rst = 1; MEM_MemRead = 0;
      tick();
      rst = 0; #1;
      check("rstw_en4", d4_en, 5'b11111);
      check("rstw_cnt4", d4_cnt, 0);

      // Saturation, CNT_W=4
      do_reset();
      EX_MemRead = 1; EX_rd = 7; ID_rs1 = 7; ID_rs1_used = 1;
      repeat (14) tick();
      check("sat_cnt3_14", d3_cnt, 14);
      repeat (6) tick();
      check("sat_cnt3_hold", d3_cnt, 15);
      check("sat_cnt1_20", d1_cnt, 20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
